mem_c_collect: RTL and testbench
================================

# mem_c_collect

Output-side de-skew buffer for the systolic matrix-multiply datapath: it captures the diagonally skewed result stream leaving the array's bottom edge, re-aligns each result row, and stores the full DIM×DIM C matrix for row-addressed readout. It is the drain-side counterpart of the A-operand skew FIFOs: those delay row lane i by i extra cycles on entry, and this block removes that skew on exit. It sits between the systolic array outputs and the host/result interface.

## Interface
- BITS_C, 16, signed width of one C element
- DIM, 8, array dimension (lanes, rows, columns); must be ≥2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a new capture; honoured only in IDLE or DONE
- in_valid  in  1  Cin beat valid this cycle; beats without it are stall cycles
- Cin  in  DIM×BITS_C signed  skewed result lanes, lane j = column j
- busy  out  1  high in CAPTURE
- done  out  1  high in DONE (matrix readable)
- rd_en  in  1  read request
- Crow  in  $clog2(DIM)  row to read
- rd_valid  out  1  Cout valid this cycle
- Cout  out  DIM×BITS_C signed  row Crow, element j = C[Crow][j]

## Operation
- States: IDLE, CAPTURE, DONE.
  - IDLE: start → CAPTURE, beat counter k=0.
  - DONE: start → CAPTURE, k=0.
  - CAPTURE: start is ignored.
- Skew contract: beat k (the k-th in_valid cycle in CAPTURE, k=0..2·DIM−2) carries C[k−j][j] on lane j when 0≤k−j<DIM; other lane values are don't-care.
- Lane j passes through a de-skew delay of DIM−1−j beats. The delay advances only on in_valid cycles, so stalls are transparent.
- At beat k=r+DIM−1, the aligned row r is written to storage row r.
- After beat 2·DIM−2 is sampled: CAPTURE → DONE.
- Reads are honoured only in DONE. rd_en in IDLE/CAPTURE is ignored: rd_valid stays 0 and Cout holds its value.
- Storage keeps the previous matrix until overwritten row by row in a new capture.
- Arithmetic: pure data movement; no sign extension or truncation. Values pass bit-exact.

## Timing
- Reset values: state IDLE, busy 0, done 0, rd_valid 0, Cout 0, storage all 0, de-skew registers 0.
- Reset mid-CAPTURE aborts the capture. No partial-done indication.
- start sampled at edge T → busy=1 after T.
  - The first beat may arrive in the cycle after T.
  - in_valid in the same cycle as start is not a beat.
- done rises on the edge that samples beat 2·DIM−2. busy falls on the same edge.
- With no stalls, done asserts 2·DIM−1 cycles after the start edge.
- Read latency is 1 cycle: rd_en at edge T → rd_valid=1 and Cout=row Crow after T. Back-to-back reads are allowed, one per cycle.
- start while in DONE, together with rd_en:
  - the read completes (rd_valid=1 next cycle, old data);
  - the state becomes CAPTURE on the same edge.
- Crow ≥ DIM is not possible when DIM is a power of 2. Otherwise it returns row 0.

## Structure
- Package mem_c_pkg holds:
  - the state typedef (IDLE/CAPTURE/DONE);
  - the beat-counter width function, $clog2(2·DIM−1).
- Sub-module deskew_lane #(DEPTH, BITS): a shift register with enable and async reset, instantiated per lane via generate with DEPTH=DIM−1−j.
  - DEPTH=0 is a wire.
  - It mirrors the A-side FIFO instantiation pattern.
- Top level holds the FSM, beat counter, storage array and read register.

## Test plan
- Basic: DIM=4, C[r][c]=16r+c, skewed with no stalls → done after 7 beats; reading rows 0..3 gives {0,1,2,3},{16,17,18,19},{32..35},{48..51}, each 1 cycle after rd_en.
- Stalls: same matrix with in_valid low on every other cycle → identical readback; done asserts on the 7th valid beat.
- Signed extremes: BITS_C=16, C[r][c]=−32768 for even c and 32767 for odd c → bit-exact readback.
- Gating: rd_en during CAPTURE → rd_valid stays 0; start during CAPTURE → capture is unaffected.
- Reset mid-capture: assert rst after beat 3 → done=0, busy=0, and every row reads 0 after a new full capture of an all-zero matrix; then a fresh capture of 16r+c reads correctly.
- Recapture: while in DONE, start a second capture with C=−(16r+c) → all rows are overwritten; back-to-back reads of rows 3,0,2 return the new values on consecutive cycles.

Source files
------------

// File: rtl/mem_c_pkg.sv
// Shared types and sizing helpers for the C-matrix collection buffer.
package mem_c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  // Beat counter must hold 0 .. 2*DIM-2.
  function automatic int unsigned beat_width(input int unsigned dim);
    return $clog2(2 * dim - 1);
  endfunction

endpackage

// File: rtl/mem_c_collect_deskew_lane.sv
// Per-lane de-skew delay: DEPTH-stage shift register advanced only on enable.
// DEPTH=0 degenerates to a wire so the last lane adds no latency.
module deskew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned BITS  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign dout        = din;
  end else begin : g_shift
    logic [BITS-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
      end else if (en) begin
        sr[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/mem_c_collect.sv
// Drain-side de-skew buffer: re-aligns the skewed systolic result stream
// into rows and stores the full C matrix for row-addressed readout.
module mem_c_collect
  import mem_c_pkg::*;
#(
  parameter int unsigned BITS_C = 16,
  parameter int unsigned DIM    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DIM*BITS_C-1:0]   Cin,
  output logic                    busy,
  output logic                    done,
  input  logic                    rd_en,
  input  logic [$clog2(DIM)-1:0]  Crow,
  output logic                    rd_valid,
  output logic [DIM*BITS_C-1:0]   Cout
);

  localparam int unsigned RW       = $clog2(DIM);
  localparam int unsigned CW       = beat_width(DIM);
  localparam int unsigned W        = DIM * BITS_C;
  localparam int unsigned LAST     = 2 * DIM - 2;
  localparam int unsigned FIRST_WR = DIM - 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q;
  logic            beat_clr;
  logic            shift_en;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [RW-1:0]   rd_row;
  logic            rd_fire;
  logic [W-1:0]    aligned;
  logic [W-1:0]    mem [DIM];

  // Lane j is delayed DIM-1-j beats so row r lines up at beat r+DIM-1.
  for (genvar j = 0; j < int'(DIM); j++) begin : g_lane
    deskew_lane #(
      .DEPTH(DIM - 1 - j),
      .BITS (BITS_C)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .din (Cin[j*BITS_C +: BITS_C]),
      .dout(aligned[j*BITS_C +: BITS_C])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == CAPTURE);
      done    <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_clr = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CAPTURE;
          beat_clr = 1'b1;
        end
      end
      CAPTURE: begin
        if (in_valid && (beat_q == CW'(LAST))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_en = (state_q == CAPTURE) && in_valid;
  assign wr_en    = shift_en && (beat_q >= CW'(FIRST_WR));
  assign wr_row   = RW'(beat_q - CW'(FIRST_WR));
  assign rd_fire  = rd_en && (state_q == DONE);
  assign rd_row   = (int'(Crow) < int'(DIM)) ? Crow : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
    end else if (beat_clr) begin
      beat_q <= '0;
    end else if (shift_en) begin
      beat_q <= beat_q + CW'(1);
    end
  end

  // Aligned row storage; previous matrix survives until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DIM); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_row] <= aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      Cout     <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) Cout <= mem[rd_row];
    end
  end

endmodule

// File: tb/tb_mem_c_collect.sv
// Directed bench for mem_c_collect at DIM=4, BITS_C=16.
module tb_mem_c_collect;

  localparam int DIM = 4;
  localparam int B   = 16;
  localparam int W   = DIM * B;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  Cin;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [1:0]    Crow;
  logic          rd_valid;
  logic [W-1:0]  Cout;

  int checks = 0;
  int errors = 0;
  int mat [DIM][DIM];

  mem_c_collect #(.BITS_C(B), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .Cin(Cin),
    .busy(busy), .done(done), .rd_en(rd_en), .Crow(Crow),
    .rd_valid(rd_valid), .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] row_exp(input int r);
    logic [W-1:0] e;
    for (int j = 0; j < DIM; j++) e[j*B +: B] = 16'(mat[r][j]);
    return e;
  endfunction

  // Skewed beat: lane j carries C[k-j][j] when in range, junk otherwise.
  function automatic logic [W-1:0] beat_word(input int k);
    logic [W-1:0] e;
    for (int j = 0; j < DIM; j++)
      e[j*B +: B] = (k - j >= 0 && k - j < DIM) ? 16'(mat[k-j][j]) : 16'hdead;
    return e;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        case (mode)
          0: mat[r][c] = 16 * r + c;
          1: mat[r][c] = (c % 2 == 0) ? -32768 : 32767;
          2: mat[r][c] = 0;
          default: mat[r][c] = -(16 * r + c);
        endcase
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; Cin = '1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic beats(input bit stall, input bit poke, output int cycles);
    int k = 0;
    cycles = 0;
    while (k < 2 * DIM - 1 && cycles < 64) begin
      if (stall && (cycles % 2 == 1)) begin
        in_valid = 1'b0; Cin = 64'h0bad_0bad_0bad_0bad;
      end else begin
        in_valid = 1'b1; Cin = beat_word(k); k++;
      end
      rd_en = poke; start = poke; Crow = 2'd1;
      @(negedge clk);
      cycles++;
      if (poke) check("rd_valid_in_capture", rd_valid, 0);
      check($sformatf("done_at_beat%0d", k), done, (k == 2 * DIM - 1));
    end
    in_valid = 1'b0; rd_en = 1'b0; start = 1'b0;
    check("done_final", done, 1);
    check("busy_final", busy, 0);
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < DIM; r++) begin
      @(negedge clk);
      rd_en = 1'b1; Crow = 2'(r);
      @(negedge clk);
      rd_en = 1'b0;
      check($sformatf("%s_rv%0d", tag, r), rd_valid, 1);
      check($sformatf("%s_row%0d", tag, r), Cout, row_exp(r));
    end
  endtask

  initial begin
    int cyc;
    logic [W-1:0] old2;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; Cin = '0; rd_en = 1'b0; Crow = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_cout", Cout, 0);

    // Read in IDLE is ignored.
    rd_en = 1'b1; Crow = 2'd1;
    @(negedge clk);
    rd_en = 1'b0;
    check("idle_rd_valid", rd_valid, 0);

    // Basic, no stalls.
    fill(0);
    start_pulse();
    beats(1'b0, 1'b0, cyc);
    check("latency_cycles", 64'(cyc), 7);
    read_all("basic");

    // Stalls every other cycle.
    beats_with_start(1'b1, cyc);
    read_all("stall");

    // Signed extremes, plus rd_en/start poked during capture.
    fill(1);
    start_pulse();
    beats(1'b0, 1'b1, cyc);
    read_all("extreme");

    // Reset mid-capture.
    fill(0);
    start_pulse();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; Cin = beat_word(k);
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    fill(2);
    beats_with_start(1'b0, cyc);
    read_all("zeros");
    fill(0);
    beats_with_start(1'b0, cyc);
    read_all("fresh");

    // Recapture from DONE with simultaneous read of old data.
    old2 = row_exp(2);
    @(negedge clk);
    start = 1'b1; rd_en = 1'b1; Crow = 2'd2; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; rd_en = 1'b0;
    check("recap_rd_valid", rd_valid, 1);
    check("recap_old_row2", Cout, old2);
    check("recap_busy", busy, 1);
    fill(3);
    beats(1'b0, 1'b0, cyc);

    // Back-to-back reads of rows 3, 0, 2.
    rd_en = 1'b1; Crow = 2'd3;
    @(negedge clk);
    Crow = 2'd0;
    check("b2b_rv3", rd_valid, 1);
    check("b2b_row3", Cout, row_exp(3));
    @(negedge clk);
    Crow = 2'd2;
    check("b2b_rv0", rd_valid, 1);
    check("b2b_row0", Cout, row_exp(0));
    @(negedge clk);
    rd_en = 1'b0;
    check("b2b_rv2", rd_valid, 1);
    check("b2b_row2", Cout, row_exp(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic beats_with_start(input bit stall, output int cycles);
    start_pulse();
    beats(stall, 1'b0, cycles);
  endtask

endmodule
